// File: rtl/pipeline_snapshot_tx_pkg.sv
// Shared debug package for the pipeline snapshot transmitter.
// Holds the latch widths shared with the pipeline top, the frame layout
// (byte counts and start indices per field), the FSM state type and a
// helper that packs the five captured buses into the padded payload.
package pipeline_snapshot_tx_pkg;

   // Pipeline latch widths, shared with the processor top
   localparam int IF_ID_SIZE  = 64;
   localparam int ID_EX_SIZE  = 129;
   localparam int EX_MEM_SIZE = 78;
   localparam int MEM_WB_SIZE = 72;
   localparam int PC_SIZE     = 32;

   // Frame framing constants
   localparam logic [7:0] HEADER      = 8'hA5;
   localparam int         FRAME_BYTES = 50;

   // Per-field byte counts after zero-extension to a byte multiple
   localparam int PC_BYTES     = (PC_SIZE + 7) / 8;
   localparam int IF_ID_BYTES  = (IF_ID_SIZE + 7) / 8;
   localparam int ID_EX_BYTES  = (ID_EX_SIZE + 7) / 8;
   localparam int EX_MEM_BYTES = (EX_MEM_SIZE + 7) / 8;
   localparam int MEM_WB_BYTES = (MEM_WB_SIZE + 7) / 8;

   // Byte index of the first byte of each field within the frame
   localparam int PC_START     = 1;
   localparam int IF_ID_START  = PC_START + PC_BYTES;
   localparam int ID_EX_START  = IF_ID_START + IF_ID_BYTES;
   localparam int EX_MEM_START = ID_EX_START + ID_EX_BYTES;
   localparam int MEM_WB_START = EX_MEM_START + EX_MEM_BYTES;

   // Last payload byte; the checksum follows it
   localparam int LAST_PAYLOAD_IDX = MEM_WB_START + MEM_WB_BYTES - 1;
   localparam int CHK_IDX          = LAST_PAYLOAD_IDX + 1;

   // Vector sizes: payload only, and full frame image (header + payload + checksum slot)
   localparam int PAYLOAD_BYTES = PC_BYTES + IF_ID_BYTES + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;
   localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;
   localparam int SNAP_BITS     = FRAME_BYTES * 8;

   // Byte index counter width (covers 0..FRAME_BYTES-1)
   localparam int IDX_W = 6;

   // Transmit sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_CHK  = 2'd2,
      ST_DONE = 2'd3
   } txState_e;

   // Zero-extend every field at its MSB end and concatenate PC first, so the
   // most significant byte of the result is the first payload byte on the wire.
   function automatic logic [PAYLOAD_BITS-1:0] packPayload(
      input logic [PC_SIZE-1:0]     pc,
      input logic [IF_ID_SIZE-1:0]  ifId,
      input logic [ID_EX_SIZE-1:0]  idEx,
      input logic [EX_MEM_SIZE-1:0] exMem,
      input logic [MEM_WB_SIZE-1:0] memWb
   );
      logic [PC_BYTES*8-1:0]     pcPad;
      logic [IF_ID_BYTES*8-1:0]  ifIdPad;
      logic [ID_EX_BYTES*8-1:0]  idExPad;
      logic [EX_MEM_BYTES*8-1:0] exMemPad;
      logic [MEM_WB_BYTES*8-1:0] memWbPad;
      pcPad                      = '0;
      ifIdPad                    = '0;
      idExPad                    = '0;
      exMemPad                   = '0;
      memWbPad                   = '0;
      pcPad[PC_SIZE-1:0]         = pc;
      ifIdPad[IF_ID_SIZE-1:0]    = ifId;
      idExPad[ID_EX_SIZE-1:0]    = idEx;
      exMemPad[EX_MEM_SIZE-1:0]  = exMem;
      memWbPad[MEM_WB_SIZE-1:0]  = memWb;
      return {pcPad, ifIdPad, idExPad, exMemPad, memWbPad};
   endfunction

endpackage

// File: rtl/pipeline_snapshot_tx_byte_mux_rom.sv
// Index-to-byte selector over the full 400-bit frame image.
// Byte 0 sits in the top eight bits; indices outside the frame read as zero.
module byte_mux_rom
   import pipeline_snapshot_tx_pkg::*;
(
   input  logic [SNAP_BITS-1:0] snapshot_i,
   input  logic [IDX_W-1:0]     index_i,
   output logic [7:0]           byte_o
);

   // Pick the byte whose frame position equals the index, MSB-first layout
   always_comb begin
      byte_o = 8'h00;
      for (int k = 0; k < FRAME_BYTES; k++) begin
         if (index_i == IDX_W'(k)) begin
            byte_o = snapshot_i[SNAP_BITS-1-8*k -: 8];
         end
      end
   end

endmodule

// File: rtl/pipeline_snapshot_tx.sv
// Pipeline snapshot transmitter.
// On request, freezes the PC and the four pipeline latches, then streams
// header, 48 payload bytes and an XOR checksum to the UART TX one byte per
// accepted cycle, honouring the TX full backpressure.
module pipeline_snapshot_tx
   import pipeline_snapshot_tx_pkg::*;
(
   input  logic                   clk_to_use,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [PC_SIZE-1:0]     i_pc,
   input  logic [IF_ID_SIZE-1:0]  i_if_id,
   input  logic [ID_EX_SIZE-1:0]  i_id_ex,
   input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
   input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
   input  logic                   i_tx_full,
   output logic                   o_tx_start,
   output logic [7:0]             o_tx_data,
   output logic                   o_busy,
   output logic                   o_done
);

   txState_e                stateQ, stateD;
   logic [IDX_W-1:0]        idxQ, idxD;
   logic [7:0]              chkQ, chkD;
   logic [PAYLOAD_BITS-1:0] snapQ, snapD;
   logic                    txStartQ, txStartD;
   logic [7:0]              txDataQ, txDataD;
   logic                    busyQ, busyD;
   logic                    doneQ, doneD;

   logic [SNAP_BITS-1:0]    frameVec;
   logic [7:0]              curByte;

   // Frame image: header, frozen payload, and an empty slot where the checksum goes
   assign frameVec = {HEADER, snapQ, 8'h00};

   byte_mux_rom uByteMux (
      .snapshot_i (frameVec),
      .index_i    (idxQ),
      .byte_o     (curByte)
   );

   // State register; reset aborts any frame in flight
   always_ff @(posedge clk_to_use or posedge i_rst) begin
      if (i_rst) begin
         stateQ <= ST_IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic: a full TX stalls progress without skipping any byte
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         ST_IDLE: begin
            if (i_start) begin
               stateD = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!i_tx_full && (idxQ == IDX_W'(LAST_PAYLOAD_IDX))) begin
               stateD = ST_CHK;
            end
         end
         ST_CHK: begin
            if (!i_tx_full) begin
               stateD = ST_DONE;
            end
         end
         ST_DONE: begin
            stateD = ST_IDLE;
         end
         default: begin
            stateD = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values; strobes and data are registered so the
   // byte appears one cycle after the edge that issued it
   always_comb begin
      txStartD = 1'b0;
      txDataD  = 8'h00;
      idxD     = idxQ;
      chkD     = chkQ;
      snapD    = snapQ;
      busyD    = (stateD != ST_IDLE);
      doneD    = (stateD == ST_DONE);
      case (stateQ)
         ST_IDLE: begin
            if (i_start) begin
               snapD = packPayload(i_pc, i_if_id, i_id_ex, i_ex_mem, i_mem_wb);
               idxD  = '0;
               chkD  = 8'h00;
            end
         end
         ST_SEND: begin
            if (!i_tx_full) begin
               txStartD = 1'b1;
               txDataD  = curByte;
               chkD     = chkQ ^ curByte;
               idxD     = idxQ + IDX_W'(1);
            end
         end
         ST_CHK: begin
            if (!i_tx_full) begin
               txStartD = 1'b1;
               txDataD  = chkQ;
            end
         end
         default: begin
            txStartD = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; the snapshot only changes on capture
   always_ff @(posedge clk_to_use or posedge i_rst) begin
      if (i_rst) begin
         idxQ     <= '0;
         chkQ     <= 8'h00;
         snapQ    <= '0;
         txStartQ <= 1'b0;
         txDataQ  <= 8'h00;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
      end else begin
         idxQ     <= idxD;
         chkQ     <= chkD;
         snapQ    <= snapD;
         txStartQ <= txStartD;
         txDataQ  <= txDataD;
         busyQ    <= busyD;
         doneQ    <= doneD;
      end
   end

   assign o_tx_start = txStartQ;
   assign o_tx_data  = txDataQ;
   assign o_busy     = busyQ;
   assign o_done     = doneQ;

endmodule

// File: tb/tb_pipeline_snapshot_tx.sv
// Directed bench for pipeline_snapshot_tx: drives frames with hand-computed
// expected bytes and checks them with immediate assertions.
module tb_pipeline_snapshot_tx;

   logic         clk_to_use;
   logic         i_rst;
   logic         i_start;
   logic [31:0]  i_pc;
   logic [63:0]  i_if_id;
   logic [128:0] i_id_ex;
   logic [77:0]  i_ex_mem;
   logic [71:0]  i_mem_wb;
   logic         i_tx_full;
   logic         o_tx_start;
   logic [7:0]   o_tx_data;
   logic         o_busy;
   logic         o_done;

   int testCount = 0;
   int failCount = 0;

   logic [7:0] got  [50];
   logic [7:0] expB [50];
   int         nStrobes;
   int         doneCyc;
   int         firstCyc;
   bit         doneSeen;
   bit         busyAtDone;
   int         quietCount;

   pipeline_snapshot_tx dut (
      .clk_to_use (clk_to_use),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_pc       (i_pc),
      .i_if_id    (i_if_id),
      .i_id_ex    (i_id_ex),
      .i_ex_mem   (i_ex_mem),
      .i_mem_wb   (i_mem_wb),
      .i_tx_full  (i_tx_full),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   // Free-running 10 ns clock
   initial begin
      clk_to_use = 1'b0;
      forever #5 clk_to_use = ~clk_to_use;
   end

   // Safety net so the run can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Load inputs and pulse i_start for one cycle, starting on a falling edge
   task automatic applyStimulus(input logic [31:0] pc, input logic [63:0] ifId,
                                input logic [128:0] idEx, input logic [77:0] exMem,
                                input logic [71:0] memWb);
      @(negedge clk_to_use);
      i_pc     = pc;
      i_if_id  = ifId;
      i_id_ex  = idEx;
      i_ex_mem = exMem;
      i_mem_wb = memWb;
      i_start  = 1'b1;
      @(negedge clk_to_use);
      i_start  = 1'b0;
   endtask

   // Record strobes until o_done or budget; optional TX-full toggling and a
   // mid-frame start pulse plus input change after pokeAt bytes
   task automatic collectFrame(input int budget, input bit toggle, input int pokeAt);
      bit poked;
      poked      = 1'b0;
      nStrobes   = 0;
      doneSeen   = 1'b0;
      doneCyc    = -1;
      firstCyc   = -1;
      busyAtDone = 1'b0;
      for (int i = 0; i < 50; i++) got[i] = 8'hxx;
      for (int c = 0; c < budget && !doneSeen; c++) begin
         @(negedge clk_to_use);
         i_start = 1'b0;
         if (o_tx_start) begin
            if (nStrobes < 50) got[nStrobes] = o_tx_data;
            if (firstCyc < 0) firstCyc = c;
            nStrobes++;
         end
         if (o_done) begin
            doneSeen   = 1'b1;
            doneCyc    = c;
            busyAtDone = o_busy;
         end
         if (!poked && pokeAt >= 0 && nStrobes == pokeAt) begin
            poked    = 1'b1;
            i_start  = 1'b1;
            i_if_id  = 64'hFFFF_FFFF_FFFF_FFFF;
            i_pc     = 32'hDEAD_BEEF;
            i_mem_wb = '1;
         end
         if (toggle) i_tx_full = ~i_tx_full;
      end
      i_start   = 1'b0;
      i_tx_full = 1'b0;
   endtask

   task automatic clearExpected();
      for (int i = 0; i < 50; i++) expB[i] = 8'h00;
      expB[0] = 8'hA5;
   endtask

   task automatic checkFrame(input string name);
      checkOutput({name, "_strobes"}, 64'(nStrobes), 64'd50);
      checkOutput({name, "_done_seen"}, 64'(doneSeen), 64'd1);
      checkOutput({name, "_busy_at_done"}, 64'(busyAtDone), 64'd1);
      for (int i = 0; i < 50; i++) begin
         checkOutput($sformatf("%s_byte%0d", name, i), 64'(got[i]), 64'(expB[i]));
      end
   endtask

   // Directed sequence
   initial begin
      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_pc      = '0;
      i_if_id   = '0;
      i_id_ex   = '0;
      i_ex_mem  = '0;
      i_mem_wb  = '0;
      i_tx_full = 1'b0;

      repeat (2) @(negedge clk_to_use);
      checkOutput("rst_tx_start", 64'(o_tx_start), 64'd0);
      checkOutput("rst_tx_data", 64'(o_tx_data), 64'd0);
      checkOutput("rst_busy", 64'(o_busy), 64'd0);
      checkOutput("rst_done", 64'(o_done), 64'd0);
      i_rst = 1'b0;

      quietCount = 0;
      repeat (4) begin
         @(negedge clk_to_use);
         if (o_tx_start || o_busy) quietCount++;
      end
      checkOutput("idle_quiet", 64'(quietCount), 64'd0);

      // All-zero frame: header, 48 zeros, checksum A5, back to back
      applyStimulus('0, '0, '0, '0, '0);
      checkOutput("t1_busy_rise", 64'(o_busy), 64'd1);
      collectFrame(200, 1'b0, -1);
      clearExpected();
      expB[49] = 8'hA5;
      checkFrame("t1");
      checkOutput("t1_first_cyc", 64'(firstCyc), 64'd0);
      checkOutput("t1_done_cyc", 64'(doneCyc), 64'd49);
      @(negedge clk_to_use);
      checkOutput("t1_busy_fall", 64'(o_busy), 64'd0);
      checkOutput("t1_done_fall", 64'(o_done), 64'd0);

      // PC = 4
      applyStimulus(32'h0000_0004, '0, '0, '0, '0);
      collectFrame(200, 1'b0, -1);
      clearExpected();
      expB[4]  = 8'h04;
      expB[49] = 8'hA1;
      checkFrame("t2");

      // ID/EX top bit only: first byte of the 17-byte field
      applyStimulus('0, '0, 129'd1 << 128, '0, '0);
      collectFrame(200, 1'b0, -1);
      clearExpected();
      expB[13] = 8'h01;
      expB[49] = 8'hA4;
      checkFrame("t3");

      // Alternating backpressure
      i_tx_full = 1'b0;
      applyStimulus(32'h1234_5678, '0, '0, '0, '0);
      collectFrame(400, 1'b1, -1);
      clearExpected();
      expB[1]  = 8'h12;
      expB[2]  = 8'h34;
      expB[3]  = 8'h56;
      expB[4]  = 8'h78;
      expB[49] = 8'hAD;
      checkFrame("t4");
      checkOutput("t4_done_cyc", 64'(doneCyc), 64'd98);

      // Field boundaries, with restart request and input changes mid-frame
      applyStimulus('0, 64'h0102_0304_0506_0708, 129'd1, 78'd1 << 77,
                    (72'd1 << 71) | 72'd1);
      collectFrame(200, 1'b0, 10);
      clearExpected();
      for (int i = 0; i < 8; i++) expB[5+i] = 8'(i + 1);
      expB[29] = 8'h01;
      expB[30] = 8'h20;
      expB[40] = 8'h80;
      expB[48] = 8'h01;
      expB[49] = 8'h0D;
      checkFrame("t5");
      quietCount = 0;
      repeat (6) begin
         @(negedge clk_to_use);
         if (o_tx_start || o_busy) quietCount++;
      end
      checkOutput("t5_no_requeue", 64'(quietCount), 64'd0);

      // Reset in the middle of a frame
      applyStimulus('0, '0, '0, '0, '0);
      nStrobes = 0;
      for (int c = 0; c < 100 && nStrobes < 20; c++) begin
         @(negedge clk_to_use);
         if (o_tx_start) nStrobes++;
      end
      checkOutput("t6_reach20", 64'(nStrobes), 64'd20);
      i_rst = 1'b1;
      @(posedge clk_to_use);
      #1;
      checkOutput("t6_tx_start", 64'(o_tx_start), 64'd0);
      checkOutput("t6_tx_data", 64'(o_tx_data), 64'd0);
      checkOutput("t6_busy", 64'(o_busy), 64'd0);
      checkOutput("t6_done", 64'(o_done), 64'd0);
      @(negedge clk_to_use);
      i_rst = 1'b0;
      quietCount = 0;
      repeat (4) begin
         @(negedge clk_to_use);
         if (o_tx_start || o_busy) quietCount++;
      end
      checkOutput("t6_quiet", 64'(quietCount), 64'd0);

      // Fresh frame after the abort starts with the header
      applyStimulus(32'h0000_0004, '0, '0, '0, '0);
      collectFrame(200, 1'b0, -1);
      clearExpected();
      expB[4]  = 8'h04;
      expB[49] = 8'hA1;
      checkFrame("t7");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
